// File: rtl/alu_writeback_32_if.sv
// rtl/alu_writeback_32_if.sv - capture/writeback bus between ALU, result stage and register file
//
// Purpose : groups the ALU-capture inputs, the register-file writeback
//           handshake and the architectural HI/LO/Overflow outputs.
// Signals : Capture, Control[4:0], reg_C[63:0], dest_idx[IDX_W-1:0]  (producer -> stage)
//           wb_ready                                             (register file -> stage)
//           in_ready, wb_valid, wb_idx, wb_data[31:0]             (stage -> consumers)
//           HI[31:0], LO[31:0], Overflow                          (stage -> consumers)
// Modports: master = producer/consumer side, slave = result stage.
interface alu_writeback_32_if #(
  parameter int IDX_W = 4
);
  logic             Capture;
  logic [4:0]       Control;
  logic [63:0]      reg_C;
  logic [IDX_W-1:0] dest_idx;
  logic             in_ready;
  logic             wb_valid;
  logic             wb_ready;
  logic [IDX_W-1:0] wb_idx;
  logic [31:0]      wb_data;
  logic [31:0]      HI;
  logic [31:0]      LO;
  logic             Overflow;

  modport master (
    output Capture, Control, reg_C, dest_idx, wb_ready,
    input  in_ready, wb_valid, wb_idx, wb_data, HI, LO, Overflow
  );

  modport slave (
    input  Capture, Control, reg_C, dest_idx, wb_ready,
    output in_ready, wb_valid, wb_idx, wb_data, HI, LO, Overflow
  );
endinterface

// File: rtl/alu_writeback_32.sv
// rtl/alu_writeback_32.sv - ALU result stage: HI/LO registers plus writeback FIFO
//
// Purpose : captures the 64-bit ALU result once per op. mul/div load HI/LO,
//           register-producing ops (including mfhi/mflo) are queued in a
//           small circular FIFO that drains to the register file over a
//           valid/ready handshake.
// Ports   : Clock  - system clock, all state on posedge
//           Clear  - synchronous active-high reset, overrides everything
//           bus    - alu_writeback_32_if.slave (capture, writeback, HI/LO, Overflow)
// Options : R0_GUARD_EN - when defined, push-class ops targeting GPR 0 are
//           discarded (no push, no Overflow effect).
module alu_writeback_32 #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 4
) (
  input logic               Clock,
  input logic               Clear,
  alu_writeback_32_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0] OP_STORE = 5'b00010;
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_BR    = 5'b10011;
  localparam logic [4:0] OP_JR    = 5'b10100;
  localparam logic [4:0] OP_OUT   = 5'b10111;
  localparam logic [4:0] OP_MFHI  = 5'b11000;
  localparam logic [4:0] OP_MFLO  = 5'b11001;
  localparam logic [4:0] OP_NOP   = 5'b11010;
  localparam logic [4:0] OP_HALT  = 5'b11011;

  logic [IDX_W-1:0] r_mem_idx  [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_ovf;

  logic             w_is_hilo;
  logic             w_is_nopush;
  logic [31:0]      w_push_data;
  logic             w_push_class;
  logic             w_push_req;
  logic             w_full;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // Op decode. mfhi/mflo read the HI/LO value registered before this edge,
  // so a mul on the previous Capture is already visible.
  always_comb begin
    w_is_hilo   = 1'b0;
    w_is_nopush = 1'b0;
    w_push_data = bus.reg_C[31:0];
    case (bus.Control)
      OP_MUL, OP_DIV:                      w_is_hilo   = 1'b1;
      OP_STORE, OP_BR, OP_JR, OP_OUT,
      OP_NOP, OP_HALT:                     w_is_nopush = 1'b1;
      OP_MFHI:                             w_push_data = r_hi;
      OP_MFLO:                             w_push_data = r_lo;
      default:                             ;
    endcase
  end

  assign w_push_class = bus.Capture && !w_is_hilo && !w_is_nopush;

`ifdef R0_GUARD_EN
  // Writes to GPR 0 are meaningless; drop them before they reach the FIFO.
  assign w_push_req = w_push_class && (bus.dest_idx != '0);
`else
  assign w_push_req = w_push_class;
`endif

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.wb_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_idx[i]  <= '0;
        r_mem_data[i] <= '0;
      end
    end else begin
      if (bus.Capture && w_is_hilo) begin
        r_hi <= bus.reg_C[63:32];
        r_lo <= bus.reg_C[31:0];
      end
      if (w_push) begin
        r_mem_idx[r_wr_ptr]  <= bus.dest_idx;
        r_mem_data[r_wr_ptr] <= w_push_data;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.in_ready = !w_full;
  assign bus.wb_valid = w_valid;
  assign bus.wb_idx   = r_mem_idx[r_rd_ptr];
  assign bus.wb_data  = r_mem_data[r_rd_ptr];
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;
  assign bus.Overflow = r_ovf;

endmodule

// File: tb/tb_alu_writeback_32.sv
// tb/tb_alu_writeback_32.sv - scoreboard testbench for alu_writeback_32
module tb_alu_writeback_32;

  localparam int DEPTH = 2;
  localparam int IDX_W = 4;

  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_STORE = 5'b00010;
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_BR    = 5'b10011;
  localparam logic [4:0] OP_JR    = 5'b10100;
  localparam logic [4:0] OP_OUT   = 5'b10111;
  localparam logic [4:0] OP_MFHI  = 5'b11000;
  localparam logic [4:0] OP_MFLO  = 5'b11001;
  localparam logic [4:0] OP_NOP   = 5'b11010;
  localparam logic [4:0] OP_HALT  = 5'b11011;
  localparam logic [4:0] OP_RSVD  = 5'b11111;

  logic clk;
  logic clear;

  alu_writeback_32_if #(.IDX_W(IDX_W)) bus ();

  alu_writeback_32 #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .Clock (clk),
    .Clear (clear),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [IDX_W+31:0] sb_q[$];
  logic [31:0]       m_hi;
  logic [31:0]       m_lo;
  logic              m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check state at negedge, advance model.
  task automatic step(input logic clr, input logic cap, input logic [4:0] ctrl,
                      input logic [63:0] c, input logic [IDX_W-1:0] dest, input logic rdy);
    logic              hilo;
    logic              nopush;
    logic              preq;
    logic              full;
    logic              mpop;
    logic [31:0]       pdata;
    logic [IDX_W+31:0] exp_e;
    clear        = clr;
    bus.Capture  = cap;
    bus.Control  = ctrl;
    bus.reg_C    = c;
    bus.dest_idx = dest;
    bus.wb_ready = rdy;
    @(negedge clk);
    check("wb_valid", 64'(bus.wb_valid), 64'(sb_q.size() != 0));
    check("in_ready", 64'(bus.in_ready), 64'(sb_q.size() < DEPTH));
    check("HI", 64'(bus.HI), 64'(m_hi));
    check("LO", 64'(bus.LO), 64'(m_lo));
    check("Overflow", 64'(bus.Overflow), 64'(m_ovf));
    if (clr) begin
      sb_q.delete();
      m_hi  = '0;
      m_lo  = '0;
      m_ovf = 1'b0;
    end else begin
      hilo   = (ctrl == OP_MUL) || (ctrl == OP_DIV);
      nopush = (ctrl == OP_STORE) || (ctrl == OP_BR) || (ctrl == OP_JR) ||
               (ctrl == OP_OUT) || (ctrl == OP_NOP) || (ctrl == OP_HALT);
      pdata  = (ctrl == OP_MFHI) ? m_hi : (ctrl == OP_MFLO) ? m_lo : c[31:0];
      preq   = cap && !hilo && !nopush;
`ifdef R0_GUARD_EN
      if (dest == '0) preq = 1'b0;
`endif
      full = (sb_q.size() == DEPTH);
      mpop = (sb_q.size() != 0) && rdy;
      if (mpop) begin
        exp_e = sb_q.pop_front();
        check("pop_idx",  64'(bus.wb_idx),  64'(exp_e[IDX_W+31:32]));
        check("pop_data", 64'(bus.wb_data), 64'(exp_e[31:0]));
      end
      if (preq) begin
        if (!full || mpop) sb_q.push_back({dest, pdata});
        else m_ovf = 1'b1;
      end
      if (cap && hilo) begin
        m_hi = c[63:32];
        m_lo = c[31:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, OP_NOP, 64'h0, '0, rdy);
  endtask

  initial begin
    sb_q.delete();
    m_hi  = '0;
    m_lo  = '0;
    m_ovf = 1'b0;
    clear = 1'b1;
    bus.Capture  = 1'b0;
    bus.Control  = '0;
    bus.reg_C    = '0;
    bus.dest_idx = '0;
    bus.wb_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset with garbage inputs (a mul that must not land)
    step(1'b1, 1'b1, OP_MUL, 64'hDEAD_BEEF_CAFE_F00D, 4'd7, 1'b1);
    check("rst_wb_idx",  64'(bus.wb_idx),  64'h0);
    check("rst_wb_data", 64'(bus.wb_data), 64'h0);
    idle(1'b0);

    // Single add, held for 3 cycles, then popped
    step(1'b0, 1'b1, OP_ADD, 64'h5, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("hold_idx",  64'(bus.wb_idx),  64'd3);
      check("hold_data", 64'(bus.wb_data), 64'd5);
      idle(1'b0);
    end
    idle(1'b1);
    idle(1'b0);

    // mul then mfhi/mflo back to back
    step(1'b0, 1'b1, OP_MUL,  64'h0000_0001_8000_0000, 4'd0, 1'b0);
    step(1'b0, 1'b1, OP_MFHI, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 1'b0);
    step(1'b0, 1'b1, OP_MFLO, 64'h1234_5678_9ABC_DEF0, 4'd5, 1'b0);
    check("mul_hi", 64'(bus.HI), 64'h1);
    check("mul_lo", 64'(bus.LO), 64'h8000_0000);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Fill, overflow, then push+pop while full
    step(1'b0, 1'b1, OP_ADD, 64'h101, 4'd1, 1'b0);
    step(1'b0, 1'b1, OP_ADD, 64'h102, 4'd2, 1'b0);
    step(1'b0, 1'b1, OP_ADD, 64'h103, 4'd3, 1'b0);
    check("ovf_set", 64'(bus.Overflow), 64'h1);
    check("full_in_ready", 64'(bus.in_ready), 64'h0);
    step(1'b0, 1'b1, OP_ADD, 64'h106, 4'd6, 1'b1);
    check("still_full", 64'(bus.in_ready), 64'h0);
    // mul/div never drop and never set Overflow beyond its sticky state
    step(1'b0, 1'b1, OP_DIV, 64'h0000_0007_0000_0003, 4'd0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Clear drops sticky Overflow; non-producing ops leave everything alone
    step(1'b1, 1'b0, OP_NOP, 64'h0, '0, 1'b0);
    step(1'b0, 1'b1, OP_MUL, 64'hAAAA_5555_1234_4321, 4'd0, 1'b0);
    step(1'b0, 1'b1, OP_STORE, 64'h11, 4'd1, 1'b1);
    step(1'b0, 1'b1, OP_BR,    64'h22, 4'd2, 1'b1);
    step(1'b0, 1'b1, OP_JR,    64'h33, 4'd3, 1'b1);
    step(1'b0, 1'b1, OP_OUT,   64'h44, 4'd4, 1'b1);
    step(1'b0, 1'b1, OP_NOP,   64'h55, 4'd5, 1'b1);
    step(1'b0, 1'b1, OP_HALT,  64'h66, 4'd6, 1'b1);
    idle(1'b1);

    // Wrap: 10 push/pop pairs
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, OP_ADD, 64'(32'h9000 + i), IDX_W'(i), 1'b1);
    end
    idle(1'b1);
    idle(1'b0);

    // Reserved code pushes low 32 bits only
    step(1'b0, 1'b1, OP_RSVD, 64'hFFFF_0000_0BAD_C0DE, 4'd9, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // dest_idx 0 while full
    step(1'b0, 1'b1, OP_ADD, 64'h201, 4'd1, 1'b0);
    step(1'b0, 1'b1, OP_ADD, 64'h202, 4'd2, 1'b0);
    step(1'b0, 1'b1, OP_ADD, 64'h200, 4'd0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // dest_idx 0 while empty
    step(1'b1, 1'b0, OP_NOP, 64'h0, '0, 1'b0);
    step(1'b0, 1'b1, OP_ADD, 64'h300, 4'd0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Clear during a pending handshake discards it
    step(1'b0, 1'b1, OP_ADD, 64'h401, 4'd8, 1'b0);
    step(1'b1, 1'b1, OP_ADD, 64'h402, 4'd9, 1'b1);
    check("clr_drain_valid", 64'(bus.wb_valid), 64'h0);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback_32.md
Name: alu_writeback_32

Overview:
- Result stage directly downstream of the 32-bit ALU. It captures the ALU's 64-bit result once per ALU operation.
- Mul/div results go into architectural HI/LO registers. mfhi/mflo and all other register-producing ops go into a small writeback FIFO.
- The FIFO drains to the register file via a valid/ready handshake, which decouples ALU issue from register-file write port availability.

Parameters:
- DEPTH, 2, writeback FIFO entries; power of two, 2..8.
- IDX_W, 4, destination register index width (16 GPRs).

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Clear  input  1  synchronous, active-high reset.
- Capture  input  1  one-cycle strobe: reg_C/Control/dest_idx valid this cycle (asserted the cycle after the ALU posedge).
- Control  input  5  ALU op select, same encoding as the ALU.
- reg_C  input  64  ALU result.
- dest_idx  input  IDX_W  destination GPR index for this op.
- in_ready  output  1  high when FIFO count < DEPTH.
- wb_valid  output  1  FIFO head valid.
- wb_ready  input  1  register file accepts head this cycle.
- wb_idx  output  IDX_W  head destination index.
- wb_data  output  32  head data.
- HI  output  32  HI register.
- LO  output  32  LO register.
- Overflow  output  1  sticky: a Capture was dropped.

Behaviour:
- Reset (Clear high at posedge): FIFO count=0, rd/wr pointers=0, wb_valid=0, wb_idx=0, wb_data=0, HI=0, LO=0, Overflow=0, in_ready=1. Clear overrides every other input the same cycle, including a mid-drain handshake, which is discarded.
- Op classification on Capture:
  - mul (01111), div (10000): HI<=reg_C[63:32], LO<=reg_C[31:0]; no FIFO push.
  - mfhi (11000): push {dest_idx, HI}. mflo (11001): push {dest_idx, LO}.
  - Both use the HI/LO value registered before this posedge. Back-to-back mul then mfhi on consecutive Captures returns the new HI.
  - store (00010), br (10011), jr (10100), out (10111), nop (11010), halt (11011): no push, no HI/LO change.
  - All other codes: push {dest_idx, reg_C[31:0]}. reg_C[63:32] is ignored.
- FIFO storage and pointers:
  - Circular buffer with wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH) and count (log2(DEPTH)+1 bits).
  - wb_valid = (count != 0). wb_idx and wb_data come combinationally from the head entry.
  - Pop occurs when wb_valid && wb_ready.
- Latency: a push at posedge N gives wb_valid=1 with that entry at N+1 if the FIFO was empty. There is no same-cycle bypass.
- Handshake rules:
  - Head entry and wb_valid hold stable until popped.
  - wb_ready while empty has no effect.
- Push + pop in the same cycle:
  - count unchanged; both pointers advance.
  - This is legal even when count==DEPTH: the pop frees the slot the same cycle. in_ready still reads 0 that cycle, and the producer may rely on it.
- Full: a push-class Capture with count==DEPTH and no simultaneous pop is dropped and sets Overflow=1. HI/LO updates from mul/div never drop and never set Overflow.
- Overflow clears only on Clear.
- Capture with an unknown/reserved code is treated as the push class above.

Optional Feature:
- Macro R0_GUARD_EN.
- Defined: push-class Captures with dest_idx==0 are discarded. There is no push and no Overflow effect, even when full. wb_idx never reads 0 while wb_valid=1.
- Undefined: dest_idx==0 is pushed like any other index.

Test Plan:
- Reset: drive Clear for 1 cycle with garbage inputs -> HI=LO=0, wb_valid=0, Overflow=0, in_ready=1.
- Capture add (00011), reg_C=0x0000_0000_0000_0005, dest_idx=3, wb_ready=0 -> next cycle wb_valid=1, wb_idx=3, wb_data=5. Hold 3 cycles stable; wb_ready=1 -> pop, wb_valid=0.
- Capture mul, reg_C=0x0000_0001_8000_0000, then next cycle mfhi dest=4, then mflo dest=5 -> HI=1, LO=0x8000_0000; FIFO yields (4,0x1) then (5,0x8000_0000); Overflow=0.
- DEPTH=2, wb_ready=0, three add Captures (dest 1,2,3) -> entries 1,2 retained, third dropped, Overflow=1, in_ready=0. Then one cycle with Capture(dest 6) plus wb_ready=1 -> entry 1 popped, 6 accepted, count stays 2.
- Captures of store, br, nop, halt -> no wb_valid, HI/LO unchanged. Wrap test: 10 push/pop pairs (alternating dest 1..10) return in order.
- With R0_GUARD_EN: add with dest_idx=0 while full -> no push, Overflow stays 0. Without the macro: the same add with dest_idx=0 while empty is pushed and wb_idx=0.
